// File: rtl/pixel_frame_driver.sv
// -----------------------------------------------------------------------------
// pixel_frame_driver
//
// Reads the 8x8 Game-of-Life pixel memory and sends it to a WS2812 LED chain.
// The block sweeps addresses 0..MAX_PIXEL. For each address it waits out the
// memory read latency and then sends the pixel byte as a 24-bit GRB word. All
// three colour bytes carry the same pixel value, and bits go out MSB first.
// After the last pixel, the data line is held low for the latch period.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   start      frame request, sampled only while idle
//   read_data  pixel byte returned by memory for the current address
//   address    pixel address to memory (row = [5:3], column = [2:0])
//   state      0 = transmitting a frame, 1 = idle (drives the Life engine)
//   led_dout   WS2812 serial data line
//   frame_done one-cycle pulse at the end of the latch period
// -----------------------------------------------------------------------------
module pixel_frame_driver #(
    parameter int T_BIT        = 15,
    parameter int T0H          = 5,
    parameter int T1H          = 10,
    parameter int LATCH_CYCLES = 600,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PIXEL    = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] read_data,
    output logic [5:0] address,
    output logic       state,
    output logic       led_dout,
    output logic       frame_done
);

    localparam int BIT_W = $clog2(T_BIT);
    localparam int LAT_W = $clog2(LATCH_CYCLES);
    localparam int FET_W = $clog2(READ_LATENCY + 1);

    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(T_BIT - 1);
    localparam logic [BIT_W-1:0] T0H_C      = BIT_W'(T0H);
    localparam logic [BIT_W-1:0] T1H_C      = BIT_W'(T1H);
    localparam logic [LAT_W-1:0] LATCH_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [FET_W-1:0] FETCH_LAST = FET_W'(READ_LATENCY - 1);
    localparam logic [5:0]       LAST_PIXEL = 6'(MAX_PIXEL);
    localparam logic [4:0]       LAST_BIT   = 5'd23;

    // Bit timing is meaningless unless 0 < T0H < T1H < T_BIT.
    if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
        $error("pixel_frame_driver: require 0 < T0H < T1H < T_BIT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_LATCH
    } fsm_t;

    fsm_t              fsm;
    logic [FET_W-1:0]  fetch_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [4:0]        bit_idx;
    logic [LAT_W-1:0]  latch_cnt;
    logic [23:0]       shift_reg;

    logic [BIT_W-1:0]  bit_cnt_nx;
    logic [BIT_W-1:0]  high_len;

    assign bit_cnt_nx = bit_cnt + BIT_W'(1);
    assign high_len   = shift_reg[23] ? T1H_C : T0H_C;

    // led_dout is registered. Each branch therefore computes the line level
    // for the bit_cnt value it is moving to, which keeps pulse widths exact.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // is updated from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shift register is cleared as well. It is small, and a
            // known value keeps the post-reset state fully deterministic.
            fsm        <= S_IDLE;
            address    <= '0;
            state      <= 1'b1;
            led_dout   <= 1'b0;
            frame_done <= 1'b0;
            fetch_cnt  <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            latch_cnt  <= '0;
            shift_reg  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    led_dout <= 1'b0;
                    address  <= '0;
                    state    <= 1'b1;
                    if (start) begin
                        fsm       <= S_FETCH;
                        state     <= 1'b0;
                        fetch_cnt <= '0;
                    end
                end

                S_FETCH: begin
                    led_dout <= 1'b0;
                    if (fetch_cnt == FETCH_LAST) begin
                        shift_reg <= {3{read_data}};
                        bit_idx   <= '0;
                        bit_cnt   <= '0;
                        led_dout  <= 1'b1;   // every bit starts high
                        fsm       <= S_SEND;
                    end else begin
                        fetch_cnt <= fetch_cnt + FET_W'(1);
                    end
                end

                S_SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            led_dout  <= 1'b0;
                            fetch_cnt <= '0;
                            // address stays at the last pixel through the
                            // latch, because the Life engine swaps buffers on it
                            if (address == LAST_PIXEL) begin
                                latch_cnt <= '0;
                                fsm       <= S_LATCH;
                            end else begin
                                address <= address + 6'd1;
                                fsm     <= S_FETCH;
                            end
                        end else begin
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            bit_idx   <= bit_idx + 5'd1;
                            led_dout  <= 1'b1;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt_nx;
                        led_dout <= (bit_cnt_nx < high_len);
                    end
                end

                S_LATCH: begin
                    led_dout <= 1'b0;
                    if (latch_cnt == LATCH_LAST) begin
                        frame_done <= 1'b1;
                        address    <= '0;
                        state      <= 1'b1;
                        fsm        <= S_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + LAT_W'(1);
                    end
                end

                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_driver.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_driver
//
// Bench for pixel_frame_driver. A small registered memory model feeds
// read_data. The decoder measures every high pulse on led_dout, rebuilds the
// 24-bit words and compares each one against a queue of expected words. The
// queue is filled whenever a frame is requested.
// -----------------------------------------------------------------------------
module tb_pixel_frame_driver;

    localparam int T_BIT        = 15;
    localparam int T0H          = 5;
    localparam int T1H          = 10;
    localparam int LATCH_CYCLES = 600;
    localparam int READ_LATENCY = 2;
    localparam int MAX_PIXEL    = 63;
    localparam int PIXEL_CYCLES = READ_LATENCY + 24 * T_BIT;
    localparam int FRAME_CYCLES = (MAX_PIXEL + 1) * PIXEL_CYCLES + LATCH_CYCLES;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] read_data;
    logic [5:0] address;
    logic       state;
    logic       led_dout;
    logic       frame_done;

    logic [7:0]  mem [64];
    logic [23:0] exp_q [$];

    int n_cmp    = 0;
    int n_err    = 0;
    int fd_count = 0;

    pixel_frame_driver #(
        .T_BIT        (T_BIT),
        .T0H          (T0H),
        .T1H          (T1H),
        .LATCH_CYCLES (LATCH_CYCLES),
        .READ_LATENCY (READ_LATENCY),
        .MAX_PIXEL    (MAX_PIXEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .read_data  (read_data),
        .address    (address),
        .state      (state),
        .led_dout   (led_dout),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Memory model with one register stage. Data is valid well before the
    // driver samples it at the end of its fetch window.
    always @(posedge clk) read_data <= mem[address];

    // Decoder and scoreboard.
    int          hi_len   = 0;
    int          nbits    = 0;
    logic [23:0] word     = '0;
    logic        prev_led = 1'b0;
    logic [23:0] exp_word;
    logic        bit_val;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (reset) begin
            hi_len   = 0;
            nbits    = 0;
            word     = '0;
            prev_led = 1'b0;
        end else begin
            if (led_dout === 1'b1) begin
                hi_len++;
            end else if (prev_led) begin
                n_cmp++;
                if (hi_len == T1H) begin
                    bit_val = 1'b1;
                end else begin
                    bit_val = 1'b0;
                    if (hi_len != T0H) begin
                        n_err++;
                        $display("FAIL bit_high_len: got %0d cycles, want %0d or %0d", hi_len, T0H, T1H);
                    end
                end
                word = {word[22:0], bit_val};
                nbits++;
                if (nbits == 24) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL pixel_word: got %h with no word expected", word);
                    end else begin
                        exp_word = exp_q.pop_front();
                        if (word !== exp_word) begin
                            n_err++;
                            $display("FAIL pixel_word: got %h, want %h", word, exp_word);
                        end
                    end
                    nbits = 0;
                end
                hi_len = 0;
            end
            prev_led = (led_dout === 1'b1);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({address, state, led_dout, frame_done} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got addr=%0d state=%b led=%b done=%b, want addr=0 state=1 led=0 done=0",
                         i, address, state, led_dout, frame_done);
            end
        end
    endtask

    task automatic test_single_bit();
        int cnt;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'hFF;
        exp_q.delete();
        exp_q.push_back(24'hFFFFFF);
        for (int i = 1; i < 64; i++) exp_q.push_back(24'h000000);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (state !== 1'b0) begin
            n_err++;
            $display("FAIL start_accept: got state=%b, want 0", state);
        end

        cnt = 0;
        while (led_dout !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (led_dout !== 1'b1 || cnt != READ_LATENCY) begin
            n_err++;
            $display("FAIL first_bit_delay: got %0d cycles (led=%b), want %0d", cnt, led_dout, READ_LATENCY);
        end

        cnt = 0;
        while (address === 6'd0 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (address !== 6'd1 || cnt != 24 * T_BIT) begin
            n_err++;
            $display("FAIL addr_step: got addr=%0d after %0d cycles, want addr=1 after %0d",
                     address, cnt, 24 * T_BIT);
        end
    endtask

    task automatic test_mid_frame_reset();
        int cnt;
        cnt = 0;
        while (address !== 6'd12 && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (address !== 6'd12) begin
            n_err++;
            $display("FAIL reach_pixel12: got addr=%0d, want 12", address);
        end
        // land on the first (high) cycle of bit 7 of pixel 12
        repeat (READ_LATENCY + 7 * T_BIT) @(negedge clk);
        n_cmp++;
        if (led_dout !== 1'b1 || exp_q.size() != 52) begin
            n_err++;
            $display("FAIL pre_reset: got led=%b pending=%0d, want led=1 pending=52", led_dout, exp_q.size());
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({led_dout, address, state} !== {1'b0, 6'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got led=%b addr=%0d state=%b, want led=0 addr=0 state=1",
                     led_dout, address, state);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({address, state, led_dout} !== {6'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got addr=%0d state=%b led=%b, want addr=0 state=1 led=0",
                     address, state, led_dout);
        end
    endtask

    task automatic test_back_to_back();
        int         cnt;
        int         lo_run;
        int         a63;
        logic [5:0] prev_addr;
        logic [5:0] nxt_addr;
        for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
        exp_q.delete();
        fd_count = 0;
        start = 1'b1;

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) exp_q.push_back(24'hA5A5A5);
            if (f == 0) begin
                cnt = 0;
                while (state !== 1'b0 && cnt < 10) begin
                    @(negedge clk);
                    cnt++;
                end
            end
            n_cmp++;
            if (state !== 1'b0 || address !== 6'd0) begin
                n_err++;
                $display("FAIL frame%0d_start: got state=%b addr=%0d, want state=0 addr=0", f, state, address);
            end

            cnt       = 0;
            lo_run    = 0;
            a63       = 0;
            prev_addr = address;
            while (state === 1'b0 && cnt < FRAME_CYCLES + 100) begin
                cnt++;
                if (address === 6'd63) a63++;
                lo_run = (led_dout === 1'b1) ? 0 : lo_run + 1;
                if (address !== prev_addr) begin
                    nxt_addr = prev_addr + 6'd1;
                    n_cmp++;
                    if (address !== nxt_addr) begin
                        n_err++;
                        $display("FAIL addr_order: got %0d after %0d, want %0d", address, prev_addr, nxt_addr);
                    end
                    prev_addr = address;
                end
                @(negedge clk);
            end

            n_cmp++;
            if (cnt != FRAME_CYCLES) begin
                n_err++;
                $display("FAIL frame%0d_length: got %0d cycles, want %0d", f, cnt, FRAME_CYCLES);
            end
            n_cmp++;
            if ({frame_done, address, state} !== {1'b1, 6'd0, 1'b1}) begin
                n_err++;
                $display("FAIL frame%0d_end: got done=%b addr=%0d state=%b, want done=1 addr=0 state=1",
                         f, frame_done, address, state);
            end
            n_cmp++;
            if (a63 != PIXEL_CYCLES + LATCH_CYCLES) begin
                n_err++;
                $display("FAIL addr63_hold: got %0d cycles, want %0d", a63, PIXEL_CYCLES + LATCH_CYCLES);
            end
            n_cmp++;
            if (lo_run != T_BIT - T1H + LATCH_CYCLES) begin
                n_err++;
                $display("FAIL latch_low: got %0d low cycles, want %0d", lo_run, T_BIT - T1H + LATCH_CYCLES);
            end
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL frame%0d_words: got %0d words undelivered, want 0", f, exp_q.size());
            end

            if (f == 2) start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (f < 2 && {state, frame_done} !== 2'b00) begin
                n_err++;
                $display("FAIL idle_gap%0d: got state=%b done=%b, want state=0 done=0", f, state, frame_done);
            end else if (f == 2 && {state, frame_done} !== 2'b10) begin
                n_err++;
                $display("FAIL final_idle: got state=%b done=%b, want state=1 done=0", state, frame_done);
            end
        end

        repeat (20) @(negedge clk);
        n_cmp++;
        if (fd_count != 3 || {state, led_dout, address} !== {1'b1, 1'b0, 6'd0}) begin
            n_err++;
            $display("FAIL frame_done_count: got %0d pulses state=%b led=%b addr=%0d, want 3 pulses state=1 led=0 addr=0",
                     fd_count, state, led_dout, address);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        test_single_bit();
        test_mid_frame_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
